// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32 ALU datapath.
// Drives the pc/IR/regfile enables, halts on an illegal encoding or a fetch timeout.
module multicycle_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instruction,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [2:0]       alu_op,
  output logic             use_imm,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t state;

  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [WAIT_W-1:0] wait_cnt;

  logic       wait_hit;
  logic       is_r;
  logic       is_i;
  logic       dec_ok;
  logic [2:0] dec_op;
  logic       dec_imm;

  // Register-source fields are consumed by the datapath, not by control.
  logic unused_rs;
  assign unused_rs = ^instruction[24:15];

  // Shared funct3 -> ALU op map; SLTU folds onto SLT.
  function automatic logic [2:0] f3_op(input logic [2:0] f3);
    logic [2:0] op;
    unique case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLT;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  assign wait_hit = (MAX_WAIT != 0) &&
                    (wait_cnt == WAIT_W'(MAX_WAIT));

  assign is_r = (opcode == OPC_R);
  assign is_i = (opcode == OPC_I);

  // Decode the captured fields into an ALU op, b-select and legality.
  always_comb begin
    dec_ok  = 1'b0;
    dec_op  = OP_ADD;
    dec_imm = 1'b0;
    unique case (1'b1)
      is_r: begin
        dec_imm = 1'b0;
        dec_ok  = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && funct3 == 3'b000);
        dec_op  = (funct3 == 3'b000 && funct7[5]) ?
                  OP_SUB : f3_op(funct3);
      end
      is_i: begin
        dec_imm = 1'b1;
        dec_ok  = !(funct3 == 3'b001 || funct3 == 3'b101) ||
                  (funct7 == 7'b0000000);
        dec_op  = f3_op(funct3);
      end
      default: begin
        dec_ok = 1'b0;
      end
    endcase
  end

  // Sequencer state, fetch capture, decode registers and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      wait_cnt      <= '0;
      retired_count <= '0;
      illegal       <= 1'b0;
      timeout       <= 1'b0;
      alu_op        <= OP_ADD;
      use_imm       <= 1'b0;
      opcode        <= '0;
      funct7        <= '0;
      funct3        <= '0;
      rd            <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            opcode   <= instruction[6:0];
            rd       <= instruction[11:7];
            funct3   <= instruction[14:12];
            funct7   <= instruction[31:25];
            wait_cnt <= '0;
            state    <= DECODE;
          end else if (wait_hit) begin
            timeout <= 1'b1;
            state   <= HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DECODE: begin
          if (dec_ok) begin
            alu_op  <= dec_op;
            use_imm <= dec_imm;
            state   <= EXEC;
          end else begin
            illegal <= 1'b1;
            state   <= HALT;
          end
        end
        EXEC: begin
          state <= WB;
        end
        WB: begin
          retired_count <= retired_count + CNT_W'(1);
          state         <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  // Datapath strobes follow the state directly and are masked by reset.
  always_comb begin
    imem_req  = !reset && (state == FETCH);
    ir_write  = imem_req && imem_ready;
    pc_write  = !reset && (state == WB);
    reg_write = pc_write && (rd != 5'd0);
  end

  assign busy   = (state != HALT);
  assign halted = (state == HALT);

endmodule
